// File: rtl/fbs_pkg.sv
// Shared types for the frame buffer scheduler: FSM states, grant encoding
// and the default BRAM word-address width.
package fbs_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_STREAM
    } state_e;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_WR,
        GNT_RD
    } grant_e;

endpackage

// File: rtl/frame_addr_counter.sv
// Frame-relative address pointer. It advances on en_i and returns to 0 after
// frame_size_i-1. clr_i takes priority over en_i. wrap_o flags the access
// that wraps the pointer.
module frame_addr_counter #(
    parameter int unsigned AW = 32
) (
    input  logic          clk_i,
    input  logic          resetn_i,
    input  logic          en_i,
    input  logic          clr_i,
    input  logic [AW-1:0] frame_size_i,
    output logic [AW-1:0] addr_o,
    output logic          wrap_o
);

    logic [AW-1:0] addr_q;
    logic [AW-1:0] addr_d;

    assign wrap_o = en_i && (addr_q == frame_size_i - AW'(1));
    assign addr_o = addr_q;

    // next pointer: clear, wrap or increment
    always_comb begin
        addr_d = addr_q;
        if (clr_i) begin
            addr_d = '0;
        end else if (en_i) begin
            addr_d = wrap_o ? '0 : addr_q + AW'(1);
        end
    end

    // pointer register
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/frame_buffer_scheduler.sv
// Shares one BRAM port between the camera drain (writes) and the HDMI refill
// (reads). Display reads are held off until a full frame has been written.
// Optional build macro: FBS_RR_ARB_EN selects round-robin arbitration in place
// of fixed write priority.
//
// state    | meaning
// S_IDLE   | no grants; frame size tracks width*depth until both are nonzero
// S_FILL   | first frame being written, no reads
// S_STREAM | writes and reads, write wrap re-latches the geometry
module frame_buffer_scheduler
    import fbs_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk_i,
    input  logic                  resetn_i,
    input  logic [15:0]           resolution_width_i,
    input  logic [15:0]           resolution_depth_i,
    input  logic                  cam_empty_i,
    input  logic                  hdmi_full_i,
    output logic                  cam_rd_o,
    output logic                  bram_wr_o,
    output logic [ADDR_WIDTH-1:0] addr_wr_o,
    output logic                  bram_rd_o,
    output logic [ADDR_WIDTH-1:0] addr_rd_o,
    output logic                  hdmi_wr_o,
    output logic                  frame_done_o,
    output logic                  page_valid_o
);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   frame_size_q, frame_size_d;
    logic                    page_valid_q, page_valid_d;
    logic                    frame_done_q, frame_done_d;
    logic                    hdmi_wr_q, hdmi_wr_d;

    logic [ADDR_WIDTH-1:0]   frame_size_new;
    logic                    dims_ok;
    logic                    wr_req, rd_req;
    grant_e                  gnt;
    logic                    wr_wrap;
    logic                    rd_wrap_unused;
    logic                    zero_clr;

    // product is taken modulo 2^ADDR_WIDTH
    assign frame_size_new = ADDR_WIDTH'(resolution_width_i) * ADDR_WIDTH'(resolution_depth_i);
    assign dims_ok        = (|resolution_width_i) && (|resolution_depth_i);

    assign wr_req = !cam_empty_i && ((state_q == S_FILL) || (state_q == S_STREAM));
    assign rd_req = (state_q == S_STREAM) && !hdmi_full_i;

`ifdef FBS_RR_ARB_EN
    // 0: write was granted last, 1: read was granted last
    logic last_grant_q, last_grant_d;

    // remember the most recent grant
    always_comb begin
        last_grant_d = last_grant_q;
        if (gnt == GNT_WR) begin
            last_grant_d = 1'b0;
        end else if (gnt == GNT_RD) begin
            last_grant_d = 1'b1;
        end
    end

    // last-grant register
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            last_grant_q <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    // single-port arbitration, at most one grant per cycle
    always_comb begin
        gnt = GNT_NONE;
        if (wr_req && rd_req) begin
`ifdef FBS_RR_ARB_EN
            gnt = last_grant_q ? GNT_WR : GNT_RD;
`else
            gnt = GNT_WR;
`endif
        end else if (wr_req) begin
            gnt = GNT_WR;
        end else if (rd_req) begin
            gnt = GNT_RD;
        end
    end

    assign bram_wr_o = (gnt == GNT_WR);
    assign cam_rd_o  = bram_wr_o;
    assign bram_rd_o = (gnt == GNT_RD);

    // state transitions and geometry re-latch at every write wrap
    always_comb begin
        state_d      = state_q;
        frame_size_d = frame_size_q;
        page_valid_d = page_valid_q;
        zero_clr     = 1'b0;
        case (state_q)
            S_IDLE: begin
                frame_size_d = frame_size_new;
                if (dims_ok) begin
                    state_d = S_FILL;
                end
            end
            S_FILL, S_STREAM: begin
                if (wr_wrap) begin
                    frame_size_d = frame_size_new;
                    if (!dims_ok) begin
                        state_d      = S_IDLE;
                        page_valid_d = 1'b0;
                        zero_clr     = 1'b1;
                    end else if (state_q == S_FILL) begin
                        state_d      = S_STREAM;
                        page_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign frame_done_d = wr_wrap;
    assign hdmi_wr_d    = bram_rd_o;

    // control registers
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q      <= S_IDLE;
            frame_size_q <= '0;
            page_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            hdmi_wr_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_size_q <= frame_size_d;
            page_valid_q <= page_valid_d;
            frame_done_q <= frame_done_d;
            hdmi_wr_q    <= hdmi_wr_d;
        end
    end

    assign page_valid_o = page_valid_q;
    assign frame_done_o = frame_done_q;
    assign hdmi_wr_o    = hdmi_wr_q;

    frame_addr_counter #(.AW(ADDR_WIDTH)) u_wr_ptr (
        .clk_i        (clk_i),
        .resetn_i     (resetn_i),
        .en_i         (bram_wr_o),
        .clr_i        (zero_clr),
        .frame_size_i (frame_size_q),
        .addr_o       (addr_wr_o),
        .wrap_o       (wr_wrap)
    );

    // the read pointer restarts with the write pointer on every geometry re-latch
    frame_addr_counter #(.AW(ADDR_WIDTH)) u_rd_ptr (
        .clk_i        (clk_i),
        .resetn_i     (resetn_i),
        .en_i         (bram_rd_o),
        .clr_i        (wr_wrap),
        .frame_size_i (frame_size_q),
        .addr_o       (addr_rd_o),
        .wrap_o       (rd_wrap_unused)
    );

endmodule
